hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage (IF/ID/EX/MEM/WB) core, which has no forwarding.
- Tracks in-flight register writes in a 3-entry scoreboard and stalls ID on RAW hazards.
- Flushes wrong-path instructions on an EX redirect and freezes the whole pipeline while data memory/IO is busy.
- Drives every pipeline-register enable/flush and keeps stall/flush performance counters.

Parameters:
- RF_WRITE_THROUGH, 1, 1 = regfile read sees same-cycle WB write, so WB slot is excluded from hazard check; 0 = WB slot included.
- CNT_W, 32, width of performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_addr_i  in  5  ID source 1
- id_rs2_addr_i  in  5  ID source 2
- id_rs1_used_i  in  1  rs1 is read
- id_rs2_used_i  in  1  rs2 is read
- id_rd_addr_i  in  5  ID destination
- id_rd_wren_i  in  1  ID instruction writes rd
- ex_redirect_i  in  1  taken branch/jump resolved in EX
- mem_busy_i  in  1  dmem/IO multi-cycle access in progress
- pc_en_o  out  1  PC update enable
- if_id_en_o  out  1  IF/ID register enable
- if_id_flush_o  out  1  IF/ID load NOP
- id_ex_en_o  out  1  ID/EX register enable
- id_ex_flush_o  out  1  ID/EX load bubble
- ex_mem_en_o  out  1  EX/MEM register enable
- mem_wb_en_o  out  1  MEM/WB register enable
- stall_cnt_o  out  CNT_W  data-stall cycle count
- flush_cnt_o  out  CNT_W  redirect count

Behaviour:
- Scoreboard: entries EX, MEM, WB; each entry is {valid, rd[4:0]}.
- hit(rs) = rs != 0 & any valid entry with rd == rs in EX or MEM, plus WB when RF_WRITE_THROUGH = 0.
- hazard = id_valid_i & ((id_rs1_used_i & hit(rs1)) | (id_rs2_used_i & hit(rs2))).
- Priority: rst_i > freeze (mem_busy_i) > redirect > hazard > run. All outputs are combinational from inputs and scoreboard.
- rst_i = 1:
  - All enables 0; both flushes 1.
  - At the edge, scoreboard and counters clear to 0.
- Freeze:
  - All enables 0; flushes 0.
  - Scoreboard and counters hold.
  - The datapath holds ex_redirect_i stable through a freeze; it is acted on in the first unfrozen cycle.
- Redirect:
  - All enables 1; if_id_flush_o = 1; id_ex_flush_o = 1.
  - The ID instruction is not issued.
  - flush_cnt_o increments.
  - The hazard is ignored (wrong-path instruction).
- Hazard:
  - pc_en_o = 0, if_id_en_o = 0; id_ex_en_o = 1 with id_ex_flush_o = 1 (bubble).
  - ex_mem_en_o = 1, mem_wb_en_o = 1.
  - stall_cnt_o increments.
- Run: all enables 1; flushes 0.
- Scoreboard update at each non-frozen, non-reset edge:
  - WB <= MEM; MEM <= EX.
  - EX <= {issue & id_rd_wren_i & (id_rd_addr_i != 0), id_rd_addr_i}, where issue = id_valid_i & ~redirect & ~hazard.
  - Otherwise EX is set invalid.
- Stall count for back-to-back dependence: 2 cycles (RF_WRITE_THROUGH = 1) or 3 (RF_WRITE_THROUGH = 0). With one independent instruction between: 1 or 2.
- rd = x0 never creates a hazard; a rd in EX with rd_wren = 0 never creates one.
- Counters saturate at all-ones.
- Reset mid-stall or mid-freeze: outputs take reset values the same cycle; the scoreboard is empty after the edge.

Decomposition:
- hazard_pkg:
  - sb_entry_t struct {logic valid; logic [4:0] rd}
  - stage enum {SB_EX, SB_MEM, SB_WB}
  - NUM_SB = 3
  - REG_X0 = 5'd0
- Sub-module hazard_sb:
  - Holds the shift-register scoreboard with the advance/insert/clear controls.
  - Outputs combinational rs1_hit/rs2_hit, gated by RF_WRITE_THROUGH.
- hazard_ctrl: priority logic, enable/flush decode, counters.

Test Plan:
- Reset: rst_i = 1 for 2 cycles → all enables 0, flushes 1, counters 0. Then `addi x5,x0,1` issues with no stall.
- RAW back-to-back: `addi x5` then `add x6,x5,x5` with RF_WRITE_THROUGH = 1 → pc_en_o = 0 for exactly 2 cycles, stall_cnt_o = 2. With RF_WRITE_THROUGH = 0 → 3 cycles, stall_cnt_o = 3.
- x0 / unused source: `addi x0,...` then `add x6,x0,x0`, and `lui x7` then `jal` whose rs1_used = 0 with rs1 = 7 → zero stalls.
- Redirect during hazard: consumer stalled in ID while ex_redirect_i = 1 → if_id_flush_o = id_ex_flush_o = 1, pc_en_o = 1, stall_cnt_o unchanged, flush_cnt_o += 1. Next cycle EX entry invalid.
- Freeze: mem_busy_i = 1 for 4 cycles while a producer is in MEM and the consumer is in ID → all enables 0, scoreboard unchanged. After release, the remaining stall count is identical to the unfrozen case.
- Reset mid-operation: rst_i pulsed with EX/MEM/WB all valid → the following instruction reading those rd issues with 0 stalls; counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard types and constants for the hazard controller
package hazard_pkg;
   localparam int NUM_SB = 3;
   localparam logic [4:0] REG_X0 = 5'd0;
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
   } sb_entry_t;
   typedef enum logic [1:0] {SB_EX, SB_MEM, SB_WB} sb_stage_e;
endpackage

// File: rtl/hazard_sb.sv
// hazard_sb: EX/MEM/WB write scoreboard with combinational source-hit lookup
module hazard_sb
   import hazard_pkg::*;
#(
   parameter int RF_WRITE_THROUGH = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       advance,
   input  logic       ins_valid,
   input  logic [4:0] ins_rd,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   output logic       rs1_hit,
   output logic       rs2_hit
);
   sb_entry_t sb [NUM_SB];

   always_ff @(posedge clk) begin
      if (rst) sb <= '{default: '0};
      else if (advance) begin
         sb[SB_WB]  <= sb[SB_MEM];
         sb[SB_MEM] <= sb[SB_EX];
         sb[SB_EX]  <= '{valid: ins_valid, rd: ins_rd};
      end
   end

   // With a write-through regfile the WB slot is already visible to ID
   function automatic logic hit(input logic [4:0] rs);
      logic h;
      h = 1'b0;
      for (int i = 0; i < NUM_SB; i++)
         if (i != int'(SB_WB) || RF_WRITE_THROUGH == 0) h = h | (sb[i].valid && sb[i].rd == rs);
      return h && rs != REG_X0;
   endfunction

   assign rs1_hit = hit(rs1);
   assign rs2_hit = hit(rs2);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW stall, redirect flush and memory freeze sequencing for the 5-stage pipe
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int RF_WRITE_THROUGH = 1,
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_valid_i,
   input  logic [4:0]       id_rs1_addr_i,
   input  logic [4:0]       id_rs2_addr_i,
   input  logic             id_rs1_used_i,
   input  logic             id_rs2_used_i,
   input  logic [4:0]       id_rd_addr_i,
   input  logic             id_rd_wren_i,
   input  logic             ex_redirect_i,
   input  logic             mem_busy_i,
   output logic             pc_en_o,
   output logic             if_id_en_o,
   output logic             if_id_flush_o,
   output logic             id_ex_en_o,
   output logic             id_ex_flush_o,
   output logic             ex_mem_en_o,
   output logic             mem_wb_en_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);
   logic rs1_hit, rs2_hit, hazard, run, stall, issue;

   assign hazard = id_valid_i & ((id_rs1_used_i & rs1_hit) | (id_rs2_used_i & rs2_hit));
   assign run    = ~rst_i & ~mem_busy_i;
   assign stall  = run & hazard & ~ex_redirect_i;
   assign issue  = id_valid_i & ~ex_redirect_i & ~hazard;

   always_comb begin
      pc_en_o       = run & ~stall;
      if_id_en_o    = run & ~stall;
      id_ex_en_o    = run;
      ex_mem_en_o   = run;
      mem_wb_en_o   = run;
      if_id_flush_o = rst_i | (run & ex_redirect_i);
      id_ex_flush_o = rst_i | (run & (ex_redirect_i | hazard));
   end

   hazard_sb #(.RF_WRITE_THROUGH(RF_WRITE_THROUGH)) u_sb (
      .clk       (clk_i),
      .rst       (rst_i),
      .advance   (run),
      .ins_valid (issue & id_rd_wren_i & (id_rd_addr_i != REG_X0)),
      .ins_rd    (id_rd_addr_i),
      .rs1       (id_rs1_addr_i),
      .rs2       (id_rs2_addr_i),
      .rs1_hit   (rs1_hit),
      .rs2_hit   (rs2_hit)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         if (stall && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
         if (run && ex_redirect_i && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of both write-through variants driven in lockstep
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1, id_valid = 1'b0, u1 = 1'b0, u2 = 1'b0, wren = 1'b0, redirect = 1'b0, busy = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
   logic b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_en, b_id_ex_flush, b_ex_mem_en, b_mem_wb_en;
   logic [31:0] stall_cnt, flush_cnt, b_stall_cnt, b_flush_cnt;
   int pass = 0, total = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.RF_WRITE_THROUGH(1), .CNT_W(32)) dut_wt (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
      .id_rs1_used_i(u1), .id_rs2_used_i(u2), .id_rd_addr_i(rd), .id_rd_wren_i(wren),
      .ex_redirect_i(redirect), .mem_busy_i(busy), .pc_en_o(pc_en), .if_id_en_o(if_id_en),
      .if_id_flush_o(if_id_flush), .id_ex_en_o(id_ex_en), .id_ex_flush_o(id_ex_flush),
      .ex_mem_en_o(ex_mem_en), .mem_wb_en_o(mem_wb_en), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
   );

   hazard_ctrl #(.RF_WRITE_THROUGH(0), .CNT_W(32)) dut_nwt (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
      .id_rs1_used_i(u1), .id_rs2_used_i(u2), .id_rd_addr_i(rd), .id_rd_wren_i(wren),
      .ex_redirect_i(redirect), .mem_busy_i(busy), .pc_en_o(b_pc_en), .if_id_en_o(b_if_id_en),
      .if_id_flush_o(b_if_id_flush), .id_ex_en_o(b_id_ex_en), .id_ex_flush_o(b_id_ex_flush),
      .ex_mem_en_o(b_ex_mem_en), .mem_wb_en_o(b_mem_wb_en), .stall_cnt_o(b_stall_cnt), .flush_cnt_o(b_flush_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] r1, input logic a1, input logic [4:0] r2,
                        input logic a2, input logic [4:0] d, input logic w);
      id_valid = v; rs1 = r1; u1 = a1; rs2 = r2; u2 = a2; rd = d; wren = w;
      #1;
   endtask

   task automatic nop();
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect = 1'b0; busy = 1'b0;
      nop();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      nop();
      tick();
      tick();
      total++;
      if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush} !== 7'b0000011)
         $display("FAIL reset_outputs got %b want 0000011", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush});
      else pass++;
      total++;
      if ({stall_cnt, flush_cnt, b_stall_cnt, b_flush_cnt} !== 128'd0)
         $display("FAIL reset_counters got %0d %0d %0d %0d want 0", stall_cnt, flush_cnt, b_stall_cnt, b_flush_cnt);
      else pass++;
      rst = 1'b0;
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
      total++;
      if ({pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, b_pc_en} !== 6'b111001)
         $display("FAIL first_issue got %b want 111001", {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, b_pc_en});
      else pass++;
      tick();
      nop();
   endtask

   task automatic test_raw(input bit gap);
      int sa, sb;
      sa = 0; sb = 0;
      do_reset();
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
      tick();
      if (gap) begin
         drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1);
         tick();
      end
      drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1);
      total++;
      if ({pc_en, if_id_en, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, if_id_flush} !== 7'b0011110)
         $display("FAIL raw_bubble gap=%0d got %b want 0011110", gap, {pc_en, if_id_en, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, if_id_flush});
      else pass++;
      for (int i = 0; i < 6; i++) begin
         if (!pc_en) sa++;
         if (!b_pc_en) sb++;
         tick();
         #1;
      end
      total++;
      if (sa != (gap ? 1 : 2) || stall_cnt !== (gap ? 32'd1 : 32'd2))
         $display("FAIL raw_wt gap=%0d got cycles %0d cnt %0d want %0d", gap, sa, stall_cnt, gap ? 1 : 2);
      else pass++;
      total++;
      if (sb != (gap ? 2 : 3) || b_stall_cnt !== (gap ? 32'd2 : 32'd3))
         $display("FAIL raw_nwt gap=%0d got cycles %0d cnt %0d want %0d", gap, sb, b_stall_cnt, gap ? 2 : 3);
      else pass++;
      nop();
   endtask

   task automatic test_no_hazard();
      do_reset();
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);
      tick();
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1);
      total++;
      if ({pc_en, b_pc_en} !== 2'b11) $display("FAIL x0_src got %b want 11", {pc_en, b_pc_en});
      else pass++;
      tick();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
      tick();
      drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1);
      total++;
      if ({pc_en, b_pc_en} !== 2'b11) $display("FAIL unused_src got %b want 11", {pc_en, b_pc_en});
      else pass++;
      tick();
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0);
      tick();
      drive(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1);
      total++;
      if ({pc_en, b_pc_en} !== 2'b11) $display("FAIL no_wren got %b want 11", {pc_en, b_pc_en});
      else pass++;
      tick();
      nop();
      total++;
      if ({stall_cnt, b_stall_cnt} !== 64'd0) $display("FAIL no_hazard_cnt got %0d %0d want 0", stall_cnt, b_stall_cnt);
      else pass++;
   endtask

   task automatic test_redirect();
      do_reset();
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
      tick();
      drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1);
      tick();
      redirect = 1'b1;
      #1;
      total++;
      if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush} !== 7'b1111111)
         $display("FAIL redirect_outputs got %b want 1111111", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush});
      else pass++;
      tick();
      redirect = 1'b0;
      drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1);
      total++;
      if (stall_cnt !== 32'd1 || flush_cnt !== 32'd1 || b_flush_cnt !== 32'd1)
         $display("FAIL redirect_counters got stall %0d flush %0d/%0d want 1 1/1", stall_cnt, flush_cnt, b_flush_cnt);
      else pass++;
      total++;
      if ({pc_en, b_pc_en} !== 2'b11) $display("FAIL redirect_ex_invalid got %b want 11", {pc_en, b_pc_en});
      else pass++;
      tick();
      nop();
   endtask

   task automatic test_freeze();
      int sa, sb, bad;
      sa = 0; sb = 0; bad = 0;
      do_reset();
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
      tick();
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
      tick();
      busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, b_pc_en, b_id_ex_en} !== 9'd0) bad++;
         tick();
      end
      total++;
      if (bad != 0) $display("FAIL freeze_outputs got %0d bad cycles want 0", bad);
      else pass++;
      total++;
      if (stall_cnt !== 32'd1 || b_stall_cnt !== 32'd1) $display("FAIL freeze_hold got %0d %0d want 1 1", stall_cnt, b_stall_cnt);
      else pass++;
      busy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (!pc_en) sa++;
         if (!b_pc_en) sb++;
         tick();
      end
      total++;
      if (sa != 1 || sb != 2 || stall_cnt !== 32'd2 || b_stall_cnt !== 32'd3)
         $display("FAIL freeze_resume got %0d/%0d cnt %0d/%0d want 1/2 cnt 2/3", sa, sb, stall_cnt, b_stall_cnt);
      else pass++;
      nop();
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
      tick();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
      tick();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
      tick();
      drive(1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 5'd12, 1'b1);
      total++;
      if ({pc_en, b_pc_en} !== 2'b00) $display("FAIL pre_reset_stall got %b want 00", {pc_en, b_pc_en});
      else pass++;
      tick();
      busy = 1'b1;
      rst = 1'b1;
      #1;
      total++;
      if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush} !== 7'b0000011)
         $display("FAIL mid_reset_outputs got %b want 0000011", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush});
      else pass++;
      tick();
      rst = 1'b0;
      busy = 1'b0;
      drive(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd12, 1'b1);
      total++;
      if ({pc_en, b_pc_en} !== 2'b11) $display("FAIL post_reset_issue got %b want 11", {pc_en, b_pc_en});
      else pass++;
      total++;
      if ({stall_cnt, flush_cnt, b_stall_cnt, b_flush_cnt} !== 128'd0)
         $display("FAIL post_reset_counters got %0d %0d %0d %0d want 0", stall_cnt, flush_cnt, b_stall_cnt, b_flush_cnt);
      else pass++;
      tick();
      nop();
   endtask

   initial begin
      test_reset();
      test_raw(1'b0);
      test_raw(1'b1);
      test_no_hazard();
      test_redirect();
      test_freeze();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
